// File: rtl/spell_stack_pkg.sv
// Shared encodings for the spell operand stack: debug opcodes and error/interrupt bit positions.
package spell_stack_pkg;

    typedef enum logic [1:0] {
        DBG_SET_SP    = 2'd0,
        DBG_WRITE_TOP = 2'd1,
        DBG_PUSH      = 2'd2,
        DBG_RSVD      = 2'd3
    } dbg_op_e;

    localparam int INTR_OVERFLOW  = 0;
    localparam int INTR_UNDERFLOW = 1;
    localparam int INTR_COUNT     = 2;

endpackage

// File: rtl/spell_stack_unit_if.sv
// Command, debug, interrupt-control and status signals of the spell operand stack.
interface spell_stack_unit_if #(
    parameter int WIDTH = 8,
    parameter int SPW   = 6
);
    logic             cmd_valid;
    logic [1:0]       cmd_need;
    logic [2:0]       cmd_delta;
    logic [1:0]       cmd_wcount;
    logic [WIDTH-1:0] cmd_top;
    logic [WIDTH-1:0] cmd_belowtop;
    logic             dbg_we;
    logic [1:0]       dbg_op;
    logic [WIDTH-1:0] dbg_data;
    logic [1:0]       int_enable;
    logic [1:0]       int_clear;
    logic             edge_mode;
    logic [SPW-1:0]   sp;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] belowtop;
    logic             empty;
    logic             full;
    logic             cmd_done;
    logic             cmd_fault;
    logic [1:0]       err_flags;
    logic             interrupt;

    modport master (
        output cmd_valid, cmd_need, cmd_delta, cmd_wcount, cmd_top, cmd_belowtop,
               dbg_we, dbg_op, dbg_data, int_enable, int_clear, edge_mode,
        input  sp, top, belowtop, empty, full, cmd_done, cmd_fault, err_flags, interrupt
    );

    modport slave (
        input  cmd_valid, cmd_need, cmd_delta, cmd_wcount, cmd_top, cmd_belowtop,
               dbg_we, dbg_op, dbg_data, int_enable, int_clear, edge_mode,
        output sp, top, belowtop, empty, full, cmd_done, cmd_fault, err_flags, interrupt
    );
endinterface

// File: rtl/spell_stack_regfile.sv
// Stack storage: two write ports (port 0 wins on collision), two combinational reads,
// synchronous clear.
module spell_stack_regfile #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we0_i,
    input  logic [AW-1:0]    wa0_i,
    input  logic [WIDTH-1:0] wd0_i,
    input  logic             we1_i,
    input  logic [AW-1:0]    wa1_i,
    input  logic [WIDTH-1:0] wd1_i,
    input  logic [AW-1:0]    ra0_i,
    output logic [WIDTH-1:0] rd0_o,
    input  logic [AW-1:0]    ra1_i,
    output logic [WIDTH-1:0] rd1_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Entry storage; port 0 is written last so it overrides port 1 at the same address
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (we1_i) begin
                mem_q[wa1_i] <= wd1_i;
            end
            if (we0_i) begin
                mem_q[wa0_i] <= wd0_i;
            end
        end
    end

    assign rd0_o = mem_q[ra0_i];
    assign rd1_o = mem_q[ra1_i];

endmodule

// File: rtl/spell_stack_unit.sv
// Parametrised operand stack: sp tracking, bounds checks, debug-port arbitration,
// sticky error flags and maskable level/edge interrupt.
module spell_stack_unit
    import spell_stack_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int CHECK = 1,
    parameter int SPW   = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    spell_stack_unit_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    // Two extra bits hold the sign and the carry of sp + delta
    localparam int EW = SPW + 2;
    localparam logic [EW-1:0]  DEPTH_E = EW'(DEPTH);
    localparam logic [SPW-1:0] DEPTH_S = SPW'(DEPTH);

    logic [SPW-1:0]        sp_q, sp_d;
    logic [INTR_COUNT-1:0] err_q, err_d, err_set_s;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;
    logic                  level_q, level_s;
    logic                  dbg_we_q;

    logic             we0_s, we1_s;
    logic [AW-1:0]    wa0_s, wa1_s, ra0_s, ra1_s;
    logic [WIDTH-1:0] wd0_s, wd1_s, rd0_s, rd1_s;

    logic [EW-1:0]  sp_ext_s, delta_ext_s, nsp_s;
    logic           under_s, over_s;
    logic [SPW-1:0] cmd_sp_s, sp_inc_s, dbg_raw_s, dbg_sp_s;

    assign sp_ext_s    = {2'b00, sp_q};
    assign delta_ext_s = {{(EW-3){bus.cmd_delta[2]}}, bus.cmd_delta};
    assign nsp_s       = sp_ext_s + delta_ext_s;

    assign under_s = (sp_ext_s < {{(EW-2){1'b0}}, bus.cmd_need}) || nsp_s[EW-1] ||
                     (nsp_s < {{(EW-2){1'b0}}, bus.cmd_wcount});
    assign over_s  = !nsp_s[EW-1] && (nsp_s > DEPTH_E);

    // Legacy mode keeps sp inside 0..DEPTH-1 by dropping the top bit
    assign cmd_sp_s  = (CHECK != 0) ? nsp_s[SPW-1:0] : SPW'(nsp_s[AW-1:0]);
    assign sp_inc_s  = (CHECK != 0) ? (sp_q + SPW'(1)) : SPW'(sp_q[AW-1:0] + AW'(1));
    assign dbg_raw_s = bus.dbg_data[SPW-1:0];
    assign dbg_sp_s  = (CHECK != 0) ? ((dbg_raw_s > DEPTH_S) ? DEPTH_S : dbg_raw_s)
                                    : SPW'(dbg_raw_s[AW-1:0]);

    assign ra0_s = sp_q[AW-1:0] - AW'(1);
    assign ra1_s = sp_q[AW-1:0] - AW'(2);

    // Next-state: debug port first, then execute command, with storage write selection
    always_comb begin
        sp_d      = sp_q;
        err_set_s = {INTR_COUNT{1'b0}};
        done_d    = 1'b0;
        fault_d   = 1'b0;
        we0_s     = 1'b0;
        we1_s     = 1'b0;
        wa0_s     = nsp_s[AW-1:0] - AW'(1);
        wa1_s     = nsp_s[AW-1:0] - AW'(2);
        wd0_s     = bus.cmd_top;
        wd1_s     = bus.cmd_belowtop;
        if (bus.dbg_we) begin
            wd0_s = bus.dbg_data;
            case (dbg_op_e'(bus.dbg_op))
                DBG_SET_SP: begin
                    sp_d = dbg_sp_s;
                end
                DBG_WRITE_TOP: begin
                    wa0_s = ra0_s;
                    if ((CHECK != 0) && (sp_q == {SPW{1'b0}})) begin
                        we0_s = 1'b0;
                    end else begin
                        we0_s = 1'b1;
                    end
                end
                DBG_PUSH: begin
                    wa0_s = sp_q[AW-1:0];
                    if (dbg_we_q) begin
                        we0_s = 1'b0;
                    end else if ((CHECK != 0) && (sp_q == DEPTH_S)) begin
                        err_set_s[INTR_OVERFLOW] = 1'b1;
                    end else begin
                        we0_s = 1'b1;
                        sp_d  = sp_inc_s;
                    end
                end
                default: begin
                    sp_d = sp_q;
                end
            endcase
        end else if (bus.cmd_valid) begin
            if ((CHECK != 0) && (under_s || over_s)) begin
                err_set_s[INTR_UNDERFLOW] = under_s;
                err_set_s[INTR_OVERFLOW]  = over_s;
                fault_d                   = 1'b1;
            end else begin
                sp_d   = cmd_sp_s;
                we0_s  = (bus.cmd_wcount != 2'd0);
                we1_s  = (bus.cmd_wcount == 2'd2);
                done_d = 1'b1;
            end
        end else begin
            sp_d = sp_q;
        end
    end

    // Set beats clear when both hit the same flag bit
    assign err_d   = (err_q & ~bus.int_clear) | err_set_s;
    assign level_s = |(err_q & bus.int_enable);

    // State, pulse, flag and edge-history registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q     <= {SPW{1'b0}};
            err_q    <= {INTR_COUNT{1'b0}};
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            level_q  <= 1'b0;
            dbg_we_q <= 1'b0;
        end else begin
            sp_q     <= sp_d;
            err_q    <= err_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            level_q  <= level_s;
            dbg_we_q <= bus.dbg_we;
        end
    end

    spell_stack_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_regfile (
        .clock (clock),
        .reset (reset),
        .we0_i (we0_s),
        .wa0_i (wa0_s),
        .wd0_i (wd0_s),
        .we1_i (we1_s),
        .wa1_i (wa1_s),
        .wd1_i (wd1_s),
        .ra0_i (ra0_s),
        .rd0_o (rd0_s),
        .ra1_i (ra1_s),
        .rd1_o (rd1_s)
    );

    assign bus.sp        = sp_q;
    assign bus.top       = ((CHECK != 0) && (sp_q == {SPW{1'b0}})) ? {WIDTH{1'b0}} : rd0_s;
    assign bus.belowtop  = ((CHECK != 0) && (sp_q < SPW'(2))) ? {WIDTH{1'b0}} : rd1_s;
    assign bus.empty     = (sp_q == {SPW{1'b0}});
    assign bus.full      = (sp_q == DEPTH_S);
    assign bus.cmd_done  = done_q;
    assign bus.cmd_fault = fault_q;
    assign bus.err_flags = err_q;
    assign bus.interrupt = bus.edge_mode ? (level_s & ~level_q) : level_s;

endmodule
